// File: rtl/coproc_pkg.sv
// Shared types for the coproc command queue: command struct, sequencer states, function codes.
package coproc_pkg;

    localparam int CP_FUNC_W = 3;
    localparam int CP_IDX_W  = 1;

    localparam logic [CP_FUNC_W-1:0] FUNC_PASS = 3'b111;

    typedef struct packed {
        logic [CP_FUNC_W-1:0] func;
        logic                 gray;
        logic [CP_IDX_W-1:0]  img_idx;
    } coproc_cmd_t;

    typedef enum logic [1:0] {
        CQ_IDLE  = 2'd0,
        CQ_ISSUE = 2'd1,
        CQ_WAIT  = 2'd2
    } cq_state_e;

endpackage

// File: rtl/coproc_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module coproc_cmd_fifo
    import coproc_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  coproc_cmd_t   wdata,
    output coproc_cmd_t   rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    coproc_cmd_t mem_q [DEPTH];
    coproc_cmd_t mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Flush leaves the queue empty whatever else happened this cycle.
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/coproc_cmd_queue.sv
// Command queue and sequencer for coproc: one start pulse per queued command, waits for done.
// Optional watchdog enabled by defining COPROC_TIMEOUT_EN.
module coproc_cmd_queue
    import coproc_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FUNC_W      = CP_FUNC_W,
    parameter int IDX_W       = CP_IDX_W,
    parameter int TIMEOUT_CYC = 131072
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [FUNC_W-1:0]          cmd_func,
    input  logic                       cmd_gray,
    input  logic [IDX_W-1:0]           cmd_img_idx,
    input  logic                       flush,
    input  logic                       cp_rdy,
    input  logic                       cp_done,
    output logic                       cp_start,
    output logic [FUNC_W-1:0]          cp_func,
    output logic                       cp_gray,
    output logic [IDX_W-1:0]           cp_img_idx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [15:0]                done_cnt,
    output logic                       err_timeout,
    input  logic                       err_clr,
    output logic [1:0]                 dbg_state
);

    // Handshake: a command is taken on any clk edge where cmd_valid & cmd_ready; cmd_ready
    // drops while full or flushing, and a pop in the same cycle never frees a slot for a push.
    cq_state_e   state_q, state_d;
    coproc_cmd_t cur_q, cur_d;
    coproc_cmd_t in_cmd, head_cmd;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic        fifo_full, fifo_empty, push, pop;

    assign in_cmd    = '{func: cmd_func, gray: cmd_gray, img_idx: cmd_img_idx};
    assign cmd_ready = !fifo_full && !flush;
    assign push      = cmd_valid && cmd_ready;

    coproc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (in_cmd),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

`ifdef COPROC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d, wd_expire;

    assign wd_expire = (state_q == CQ_WAIT) && (wd_q == WD_W'(TIMEOUT_CYC - 1)) && !cp_done;

    always_comb begin
        wd_d = wd_q;
        if (state_q == CQ_ISSUE) begin
            wd_d = '0;
        end else if (state_q == CQ_WAIT) begin
            wd_d = wd_q + 1'b1;
        end
        err_d = err_q;
        if (wd_expire) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYC == 0);
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        done_cnt_d = done_cnt_q;
        pop        = 1'b0;
        case (state_q)
            CQ_IDLE: begin
                if (!fifo_empty && cp_rdy) begin
                    pop     = 1'b1;
                    cur_d   = head_cmd;
                    state_d = CQ_ISSUE;
                end
            end
            CQ_ISSUE: state_d = CQ_WAIT;
            CQ_WAIT: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (cp_done) begin
                    state_d    = CQ_IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                end
`ifdef COPROC_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = CQ_IDLE;
                end
`endif
            end
            default: state_d = CQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CQ_IDLE;
            cur_q      <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign cp_start   = (state_q == CQ_ISSUE);
    assign busy       = (state_q != CQ_IDLE);
    assign cp_func    = cur_q.func;
    assign cp_gray    = cur_q.gray;
    assign cp_img_idx = cur_q.img_idx;
    assign done_cnt   = done_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_coproc_cmd_queue.sv
// Bench for coproc_cmd_queue: queue-based reference model compared every cycle plus directed checks.
module tb_coproc_cmd_queue;
    import coproc_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_func = '0;
    logic        cmd_gray = 1'b0;
    logic [0:0]  cmd_img_idx = '0;
    logic        flush = 1'b0;
    logic        cp_rdy = 1'b0;
    logic        cp_done = 1'b0;
    logic        cp_start;
    logic [2:0]  cp_func;
    logic        cp_gray;
    logic [0:0]  cp_img_idx;
    logic        busy;
    logic [2:0]  q_count;
    logic [15:0] done_cnt;
    logic        err_timeout;
    logic        err_clr = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coproc_cmd_queue #(
        .DEPTH(DEPTH), .FUNC_W(3), .IDX_W(1), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .cmd_gray(cmd_gray), .cmd_img_idx(cmd_img_idx),
        .flush(flush), .cp_rdy(cp_rdy), .cp_done(cp_done), .cp_start(cp_start),
        .cp_func(cp_func), .cp_gray(cp_gray), .cp_img_idx(cp_img_idx), .busy(busy),
        .q_count(q_count), .done_cnt(done_cnt), .err_timeout(err_timeout),
        .err_clr(err_clr), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending commands in a queue, plus the phase of the in-flight command
    // (0 none, 1 start cycle, 2 awaiting done).
    coproc_cmd_t m_q[$];
    coproc_cmd_t m_cur = '0;
    int          m_phase = 0;
    int          m_done = 0;
    int          m_wait = 0;
    bit          m_err = 1'b0;
    bit          m_push_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cur   = '0;
            m_phase = 0;
            m_done  = 0;
            m_wait  = 0;
            m_err   = 1'b0;
        end else begin
            m_push_ok = cmd_valid && !flush && (m_q.size() < DEPTH);
            if (m_phase == 0) begin
                if (m_q.size() > 0 && cp_rdy) begin
                    m_cur   = m_q.pop_front();
                    m_phase = 1;
                end
`ifdef COPROC_TIMEOUT_EN
                if (err_clr) m_err = 1'b0;
`endif
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_wait  = 1;
`ifdef COPROC_TIMEOUT_EN
                if (err_clr) m_err = 1'b0;
`endif
            end else begin
                if (cp_done) begin
                    m_phase = 0;
                    m_done  = (m_done + 1) % 65536;
`ifdef COPROC_TIMEOUT_EN
                    if (err_clr) m_err = 1'b0;
                end else if (m_wait == TMO) begin
                    m_phase = 0;
                    m_err   = 1'b1;
                end else begin
                    m_wait++;
                    if (err_clr) m_err = 1'b0;
`endif
                end
            end
            if (flush) m_q.delete();
            else if (m_push_ok) m_q.push_back('{cmd_func, cmd_gray, cmd_img_idx});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_start", 32'(cp_start), 32'(m_phase == 1));
            check("m_busy", 32'(busy), 32'(m_phase != 0));
            check("m_func", 32'(cp_func), 32'(m_cur.func));
            check("m_gray", 32'(cp_gray), 32'(m_cur.gray));
            check("m_idx", 32'(cp_img_idx), 32'(m_cur.img_idx));
            check("m_qcount", 32'(q_count), 32'(m_q.size()));
            check("m_donecnt", 32'(done_cnt), 32'(m_done));
            check("m_err", 32'(err_timeout), 32'(m_err));
            check("m_ready", 32'(cmd_ready), 32'((m_q.size() < DEPTH) && !flush));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] f, input logic g, input logic i);
        cmd_valid   = 1'b1;
        cmd_func    = f;
        cmd_gray    = g;
        cmd_img_idx = i;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_start(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            tick();
            seen = cp_start;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic done_pulse();
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
    endtask

    logic [2:0] f_exp [4];
    logic       g_exp [4];
    logic       i_exp [4];

    initial begin
        f_exp = '{3'b010, 3'b110, 3'b011, 3'b111};
        g_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
        i_exp = '{1'b0, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_qcount", 32'(q_count), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Reset asserted while a command is waiting for done.
        cp_rdy = 1'b1;
        push_cmd(3'b101, 1'b1, 1'b1);
        wait_start("t1_start", 5);
        tick();
        check("t1_busy_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_start", 32'(cp_start), 32'd0);
        check("t1_async_func", 32'(cp_func), 32'd0);
        check("t1_async_gray", 32'(cp_gray), 32'd0);
        check("t1_async_idx", 32'(cp_img_idx), 32'd0);
        check("t1_async_busy", 32'(busy), 32'd0);
        check("t1_async_qcount", 32'(q_count), 32'd0);
        check("t1_async_done", 32'(done_cnt), 32'd0);
        check("t1_async_err", 32'(err_timeout), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("t1_rel_qcount", 32'(q_count), 32'd0);
        check("t1_rel_ready", 32'(cmd_ready), 32'd1);

        // Single command, done after 100 cycles.
        push_cmd(FUNC_PASS, 1'b0, 1'b0);
        check("t2_no_early_start", 32'(cp_start), 32'd0);
        wait_start("t2_start", 5);
        check("t2_func", 32'(cp_func), 32'd7);
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        check("t2_start_one_cycle", 32'(cp_start), 32'd0);
        check("t2_func_held", 32'(cp_func), 32'd7);
        repeat (98) tick();
        done_pulse();
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_busy_after", 32'(busy), 32'd0);

        // Fill past capacity with the coprocessor not ready.
        cp_rdy = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_func    = (k < 4) ? f_exp[k] : 3'b001;
            cmd_gray    = (k < 4) ? g_exp[k] : 1'b0;
            cmd_img_idx = (k < 4) ? i_exp[k] : 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        check("t3_qcount_full", 32'(q_count), 32'd4);
        check("t3_ready_full", 32'(cmd_ready), 32'd0);
        cp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start("t3_start", 5);
            check("t3_order_func", 32'(cp_func), 32'(f_exp[k]));
            check("t3_order_gray", 32'(cp_gray), 32'(g_exp[k]));
            check("t3_order_idx", 32'(cp_img_idx), 32'(i_exp[k]));
            repeat (5) tick();
            done_pulse();
        end
        check("t3_done_cnt", 32'(done_cnt), 32'd5);
        check("t3_qcount_empty", 32'(q_count), 32'd0);

        // Flush three queued commands while one is in flight.
        push_cmd(3'b001, 1'b0, 1'b0);
        wait_start("t4_start", 5);
        tick();
        push_cmd(3'b010, 1'b1, 1'b0);
        push_cmd(3'b011, 1'b0, 1'b1);
        push_cmd(3'b100, 1'b1, 1'b1);
        check("t4_qcount3", 32'(q_count), 32'd3);
        flush = 1'b1;
        cmd_valid = 1'b1;
        cmd_func = 3'b110;
        #1;
        check("t4_ready_flush", 32'(cmd_ready), 32'd0);
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("t4_qcount0", 32'(q_count), 32'd0);
        repeat (3) tick();
        check("t4_inflight_busy", 32'(busy), 32'd1);
        done_pulse();
        check("t4_done_cnt", 32'(done_cnt), 32'd6);
        tick();
        check("t4_nothing_issued", 32'(busy), 32'd0);

        // Spurious done in IDLE, then an early done during the start cycle.
        done_pulse();
        done_pulse();
        check("t5_idle_done_cnt", 32'(done_cnt), 32'd6);
        check("t5_idle_busy", 32'(busy), 32'd0);
        push_cmd(3'b000, 1'b1, 1'b0);
        wait_start("t5_start", 5);
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        check("t5_issue_done_cnt", 32'(done_cnt), 32'd6);
        check("t5_issue_busy", 32'(busy), 32'd1);
        done_pulse();
        check("t5_done_cnt", 32'(done_cnt), 32'd7);

`ifdef COPROC_TIMEOUT_EN
        // Watchdog expiry, then done arriving on the expiry cycle.
        push_cmd(3'b100, 1'b0, 1'b0);
        wait_start("t6_start_x", 5);
        push_cmd(3'b011, 1'b1, 1'b1);
        repeat (63) tick();
        check("t6_err_before", 32'(err_timeout), 32'd0);
        check("t6_busy_before", 32'(busy), 32'd1);
        tick();
        check("t6_err_set", 32'(err_timeout), 32'd1);
        check("t6_busy_abort", 32'(busy), 32'd0);
        check("t6_done_cnt_abort", 32'(done_cnt), 32'd7);
        tick();
        check("t6_start_y", 32'(cp_start), 32'd1);
        check("t6_func_y", 32'(cp_func), 32'd3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6_err_clr", 32'(err_timeout), 32'd0);
        repeat (63) tick();
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        check("t6_expiry_done_err", 32'(err_timeout), 32'd0);
        check("t6_expiry_done_cnt", 32'(done_cnt), 32'd8);
        check("t6_expiry_busy", 32'(busy), 32'd0);
`else
        // Without the watchdog a command waits indefinitely.
        push_cmd(3'b100, 1'b0, 1'b0);
        wait_start("t6_start", 5);
        err_clr = 1'b1;
        repeat (200) tick();
        err_clr = 1'b0;
        check("t6_still_busy", 32'(busy), 32'd1);
        check("t6_no_err", 32'(err_timeout), 32'd0);
        done_pulse();
        check("t6_done_cnt", 32'(done_cnt), 32'd8);
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
